// File: rtl/div_unit.sv
// div_unit - multi-cycle radix-2 restoring divider for the EX stage.
//
// Produces quotient and remainder of two WIDTH-bit operands, signed or
// unsigned, retiring one quotient bit per clock. Operands are reduced to
// magnitudes on acceptance, divided as unsigned numbers, and the signs are
// restored in a single correction cycle at the end.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous reset, active low
//   signed_div_i  1 = signed divide, 0 = unsigned; sampled with start_i
//   opdata1_i     dividend; sampled with start_i
//   opdata2_i     divisor; sampled with start_i
//   start_i       request, held high until ready_o has been seen
//   annul_i       cancels the current operation (pipeline flush)
//   result_o      {remainder, quotient}, meaningful only while ready_o = 1
//   ready_o       result valid
//   pausereq_o    stall request towards ctrl: start_i & ~ready_o
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               pausereq_o
);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_BYZERO,
    ST_ON,
    ST_END
  } divState_e;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  divState_e        state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] partRem_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic             negQuot_q;
  logic             negRem_q;

  logic [WIDTH:0]   shifted;
  logic             canSub;
  logic [WIDTH-1:0] partRem_d;
  logic [WIDTH-1:0] dividend_d;
  logic [WIDTH-1:0] absOp1;
  logic [WIDTH-1:0] absOp2;
  logic [WIDTH-1:0] quotFinal;
  logic [WIDTH-1:0] remFinal;

  // One restoring step: the top bit of the working dividend shifts into the
  // partial remainder and the trial-subtract outcome shifts in as a new
  // quotient bit, so after WIDTH steps dividend_q holds the quotient.
  // The compare is WIDTH+1 bits wide because the shifted remainder can
  // exceed WIDTH bits; the difference itself always fits in WIDTH bits.
  always_comb begin
    shifted    = {partRem_q, dividend_q[WIDTH-1]};
    canSub     = shifted >= {1'b0, divisor_q};
    partRem_d  = canSub ? (shifted[WIDTH-1:0] - divisor_q) : shifted[WIDTH-1:0];
    dividend_d = {dividend_q[WIDTH-2:0], canSub};
  end

  // Magnitudes of the incoming operands. The most negative value negates to
  // itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    absOp1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + ONE) : opdata1_i;
    absOp2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + ONE) : opdata2_i;
  end

  // Sign restoration: the quotient is negative when the operand signs
  // differ, and the remainder takes the sign of the dividend.
  always_comb begin
    quotFinal = negQuot_q ? (~dividend_q + ONE) : dividend_q;
    remFinal  = negRem_q  ? (~partRem_q  + ONE) : partRem_q;
  end

  assign pausereq_o = start_i & ~ready_o;

  // Control FSM and datapath registers. Reset beats annul, annul beats
  // start. Operands are copied on acceptance, so later input changes do not
  // disturb a running division.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_FREE;
      count_q    <= '0;
      partRem_q  <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      negQuot_q  <= 1'b0;
      negRem_q   <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else if (annul_i) begin
      state_q  <= ST_FREE;
      count_q  <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_FREE: begin
          if (start_i) begin
            negQuot_q  <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            negRem_q   <= signed_div_i & opdata1_i[WIDTH-1];
            dividend_q <= absOp1;
            divisor_q  <= absOp2;
            partRem_q  <= '0;
            count_q    <= '0;
            state_q    <= (opdata2_i == '0) ? ST_BYZERO : ST_ON;
          end
        end
        ST_BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
          state_q  <= ST_END;
        end
        ST_ON: begin
          // Once all WIDTH bits are done, spend one cycle fixing up signs.
          if (count_q == LAST_CNT) begin
            result_o <= {remFinal, quotFinal};
            ready_o  <= 1'b1;
            state_q  <= ST_END;
          end else begin
            partRem_q  <= partRem_d;
            dividend_q <= dividend_d;
            count_q    <= count_q + CNT_W'(1);
          end
        end
        ST_END: begin
          // Hold the result until the requester drops start_i.
          if (!start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state_q  <= ST_FREE;
          end
        end
        default: begin
          state_q <= ST_FREE;
        end
      endcase
    end
  end

endmodule
